nes_vga_scan: RTL and testbench
===============================

# nes_vga_scan

Video scan-out engine: the read side of the render engine's video buffer. Sweeps 640x480@60 VGA timing, reads the 256x240 frame buffer (two banks, ping-pong) with 2x pixel doubling centred in the raster, and maps each 6-bit NES system colour to 12-bit RGB. It also generates the vblank indication and the bank-select that the renderer writes against.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- X_OFFSET, 64, first visible column of the NES image (left border width)

Ports:
- i_clk  in  1  pixel clock (25.175 MHz nominal); one clock
- i_rstn  in  1  asynchronous, active-low reset
- i_frame_rdy  in  1  one-cycle pulse from the renderer: back bank complete
- o_rd_bank  out  1  bank being displayed; the renderer writes bank ~o_rd_bank
- o_vblank  out  1  high on lines V_ACTIVE..V_TOTAL-1
- o_vbuf_addr  out  17  {bank, nes_y[7:0], nes_x[7:0]}
- o_vbuf_re  out  1  read enable to the synchronous buffer RAM
- i_vbuf_rdata  in  8  RAM data, valid one cycle after o_vbuf_re; [5:0] colour index, [7:6] ignored
- o_hsync / o_vsync  out  1  active-low syncs
- o_de  out  1  display enable (the full 640x480 region)
- o_rgb  out  12  {R[3:0],G[3:0],B[3:0]}

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=800), v_cnt 0..V_TOTAL-1 (525). h wraps every cycle at 799; v increments when h wraps, and v wraps 524->0.
- Stage 0 (counters): active = h<640 && v<480; image = active && X_OFFSET<=h<X_OFFSET+512.
- Stage 1 (registered): o_vbuf_re=image; o_vbuf_addr={o_rd_bank, v[8:1], (h-X_OFFSET)[8:1]}, address 0 when not image. Each word is read twice per line and each line on two VGA lines. Reads are not deduplicated.
- Stage 2: i_vbuf_rdata arrives; the image flag is delayed one stage.
- Stage 3 (registered outputs): o_rgb=rom(rdata[5:0]) if image, else 12'h000. Border and blanking are black. o_de, o_hsync and o_vsync come from the stage-0 values delayed 3 stages.
- hsync low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vsync low on lines 490..491.
- Bank swap: i_frame_rdy sets a pending flag. At h=0,v=480, if the flag is pending (or i_frame_rdy is high that cycle), o_rd_bank toggles and the flag clears. Otherwise the same bank is redisplayed. A frame_rdy pulse arriving while the flag is already pending is absorbed, so there is one swap per vblank at most.
- o_vblank is registered: it rises at h=0,v=480 in the same cycle as the swap and falls at h=0,v=0.
- Width rules: h-X_OFFSET is computed in 10 bits and only bits [8:1] are used. The image range guarantees a result of 0..511.

## Timing
- Reset values: o_hsync=1, o_vsync=1, o_de=0, o_rgb=0, o_vbuf_re=0, o_vbuf_addr=0, o_vblank=0, o_rd_bank=0, pending=0, h=v=0.
- Latency from counters to pins is 3 cycles. The first o_de=1 appears 3 cycles after reset deassertion.
- RAM read latency is exactly 1 cycle and has no backpressure.
- Reset mid-frame: all state returns to its reset value immediately (async). A pending swap is lost.
- o_rd_bank and o_vblank change only at h=0,v=480 or h=0,v=0. There is no other glitch window.

## Structure
- Shared package nes_video_pkg: timing constants (H_TOTAL, V_TOTAL, sync positions), NES_W=256, NES_H=240, and the RGB444 type.
- Sub-module nes_rgb_rom: 64x12 combinational/registered NES system palette ROM, indexed by rdata[5:0]. Index 0x0D and 0x0E..0x0F, 0x1E..0x1F, 0x2E..0x2F, 0x3E..0x3F map to 12'h000.

## Test plan
- Reset release -> syncs high, de low; de rises at cycle 3; hsync falls at cycle 656+3 and lasts 96 cycles; line period 800; frame period 420000 cycles.
- RAM model returns addr[7:0] as data -> o_vbuf_addr on line v=2, h=64..67 reads {0,8'd1,8'd0},{..0},{..1},{..1}; o_rgb tracks rom(0),rom(0),rom(1),rom(1) 3 cycles later.
- Border: h=0..63 and 576..639 -> o_vbuf_re=0, o_rgb=0, o_de=1.
- i_frame_rdy pulse at v=100 -> o_rd_bank 0->1 at h=0,v=480, coincident with o_vblank rising; no pulse in the next frame -> bank stays 1.
- i_frame_rdy coincident with h=0,v=480 -> swap happens that cycle; two pulses in one frame -> only a single toggle.
- Assert i_rstn low at v=300,h=400 with pending=1 -> all outputs at reset values immediately; after release, bank=0 and counters restart from 0,0.

Source files
------------

// File: rtl/nes_video_pkg.sv
// Shared video constants and types for the NES scan-out path.
// Default timing is 640x480@60 with a 256x240 image doubled to 512x480.
package nes_video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_X_OFFSET = 64;

  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP
                          + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP
                          + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  localparam int NES_W = 256;
  localparam int NES_H = 240;

  typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/nes_vga_scan_if.sv
// Read port of the ping-pong video buffer RAM.
// Synchronous RAM: rdata valid one cycle after re.
interface nes_vga_scan_if;
  logic [16:0] addr;
  logic        re;
  logic [7:0]  rdata;

  modport master (
    output addr,
    output re,
    input  rdata
  );

  modport slave (
    input  addr,
    input  re,
    output rdata
  );
endinterface

// File: rtl/nes_rgb_rom.sv
// NES 64-entry system palette to RGB444.
// Purely combinational; the caller registers the result.
module nes_rgb_rom
  import nes_video_pkg::*;
(
  input  logic [5:0] idx,
  output rgb444_t    rgb
);

  localparam rgb444_t PAL [64] = '{
    12'h666, 12'h028, 12'h10A, 12'h409,
    12'h607, 12'h703, 12'h700, 12'h510,
    12'h320, 12'h040, 12'h040, 12'h041,
    12'h045, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h06D, 12'h44F, 12'h82F,
    12'hB2C, 12'hD27, 12'hD31, 12'hA50,
    12'h770, 12'h290, 12'h0A0, 12'h0A3,
    12'h089, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h5BF, 12'h89F, 12'hB7F,
    12'hF6F, 12'hF6B, 12'hF85, 12'hFA3,
    12'hCC2, 12'h8E3, 12'h4F5, 12'h2E9,
    12'h2DE, 12'h555, 12'h000, 12'h000,
    12'hFFF, 12'hBEF, 12'hCDF, 12'hDCF,
    12'hFCF, 12'hFCE, 12'hFCC, 12'hFDA,
    12'hEE9, 12'hCFA, 12'hAFB, 12'h9FD,
    12'h9FF, 12'hBBB, 12'h000, 12'h000
  };

  assign rgb = PAL[idx];

endmodule

// File: rtl/nes_vga_scan.sv
// VGA scan-out of the NES frame buffer: timing, 2x doubling,
// ping-pong bank select, palette lookup. Counters to pins = 3 cycles.
module nes_vga_scan
  import nes_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int X_OFFSET = DEF_X_OFFSET
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_frame_rdy,
  output logic       o_rd_bank,
  output logic       o_vblank,
  nes_vga_scan_if.master vbuf,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output rgb444_t    o_rgb
);

  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA   = 10'(H_ACTIVE);
  localparam logic [9:0] VA   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_S  = 10'(X_OFFSET);
  localparam logic [9:0] X_E  = 10'(X_OFFSET + 2 * NES_W);

  logic [9:0] h;
  logic [9:0] v;
  logic [9:0] hx;
  logic       act0;
  logic       img0;
  logic       hs0;
  logic       vs0;
  logic       swap_pt;
  logic       top_pt;
  logic       pend;

  logic       de1, hs1, vs1;
  logic       de2, hs2, vs2, img2;
  rgb444_t    pal_rgb;
  logic       unused_bits;

  assign act0    = (h < HA) && (v < VA);
  assign img0    = act0 && (h >= X_S) && (h < X_E);
  assign hs0     = !((h >= HS_S) && (h < HS_E));
  assign vs0     = !((v >= VS_S) && (v < VS_E));
  assign hx      = h - X_S;
  assign swap_pt = (h == '0) && (v == VA);
  assign top_pt  = (h == '0) && (v == '0);

  assign unused_bits = ^{vbuf.rdata[7:6], hx[9], hx[0], v[9], v[0]};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Swap only at the top of vblank; extra pulses fold into pend.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rd_bank <= 1'b0;
      o_vblank  <= 1'b0;
      pend      <= 1'b0;
    end else if (swap_pt) begin
      o_vblank <= 1'b1;
      if (pend || i_frame_rdy) begin
        o_rd_bank <= ~o_rd_bank;
        pend      <= 1'b0;
      end
    end else begin
      pend <= pend | i_frame_rdy;
      if (top_pt) o_vblank <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vbuf.re   <= 1'b0;
      vbuf.addr <= '0;
      de1       <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
    end else begin
      vbuf.re   <= img0;
      vbuf.addr <= img0 ? {o_rd_bank, v[8:1], hx[8:1]} : '0;
      de1       <= act0;
      hs1       <= hs0;
      vs1       <= vs0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      de2  <= 1'b0;
      hs2  <= 1'b1;
      vs2  <= 1'b1;
      img2 <= 1'b0;
    end else begin
      de2  <= de1;
      hs2  <= hs1;
      vs2  <= vs1;
      img2 <= vbuf.re;
    end
  end

  nes_rgb_rom u_rom (
    .idx (vbuf.rdata[5:0]),
    .rgb (pal_rgb)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_de    <= 1'b0;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_rgb   <= '0;
    end else begin
      o_de    <= de2;
      o_hsync <= hs2;
      o_vsync <= vs2;
      o_rgb   <= img2 ? pal_rgb : 12'h000;
    end
  end

endmodule

// File: tb/tb_nes_vga_scan.sv
// Bench: small-raster instance against a frame-level model,
// plus directed checks on a full 640x480 instance.
module tb_nes_vga_scan;

  localparam int HA = 80, HFP = 4, HSY = 8, HBP = 8;
  localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3;
  localparam int XO = 8;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FR = HT * VT;

  localparam logic [11:0] PAL [64] = '{
    12'h666, 12'h028, 12'h10A, 12'h409,
    12'h607, 12'h703, 12'h700, 12'h510,
    12'h320, 12'h040, 12'h040, 12'h041,
    12'h045, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h06D, 12'h44F, 12'h82F,
    12'hB2C, 12'hD27, 12'hD31, 12'hA50,
    12'h770, 12'h290, 12'h0A0, 12'h0A3,
    12'h089, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h5BF, 12'h89F, 12'hB7F,
    12'hF6F, 12'hF6B, 12'hF85, 12'hFA3,
    12'hCC2, 12'h8E3, 12'h4F5, 12'h2E9,
    12'h2DE, 12'h555, 12'h000, 12'h000,
    12'hFFF, 12'hBEF, 12'hCDF, 12'hDCF,
    12'hFCF, 12'hFCE, 12'hFCC, 12'hFDA,
    12'hEE9, 12'hCFA, 12'hAFB, 12'h9FD,
    12'h9FF, 12'hBBB, 12'h000, 12'h000
  };

  typedef struct {
    bit          de, hs, vs, re;
    logic [16:0] addr;
    logic [11:0] rgb;
  } ent_t;

  logic clk = 1'b0;
  logic rstn;
  logic frame_rdy;

  logic        s_bank, s_vbl, s_hs, s_vs, s_de;
  logic [11:0] s_rgb;
  logic        f_bank, f_vbl, f_hs, f_vs, f_de;
  logic [11:0] f_rgb;

  nes_vga_scan_if s_if ();
  nes_vga_scan_if f_if ();

  logic [7:0] mem [0:131071];

  int n_tests = 0;
  int n_fail  = 0;
  int t;
  bit mbank, mpend, mvbl;
  bit sched_on, full_on;
  ent_t ring [4];

  always #5 clk = ~clk;

  nes_vga_scan #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .X_OFFSET(XO)
  ) dut_s (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_frame_rdy(frame_rdy),
    .o_rd_bank  (s_bank),
    .o_vblank   (s_vbl),
    .vbuf       (s_if),
    .o_hsync    (s_hs),
    .o_vsync    (s_vs),
    .o_de       (s_de),
    .o_rgb      (s_rgb)
  );

  nes_vga_scan dut_f (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_frame_rdy(frame_rdy),
    .o_rd_bank  (f_bank),
    .o_vblank   (f_vbl),
    .vbuf       (f_if),
    .o_hsync    (f_hs),
    .o_vsync    (f_vs),
    .o_de       (f_de),
    .o_rgb      (f_rgb)
  );

  always @(posedge clk) if (s_if.re) s_if.rdata <= mem[s_if.addr];
  always @(posedge clk) if (f_if.re) f_if.rdata <= f_if.addr[7:0];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)",
               tag, got, exp, t);
    end
  endtask

  function automatic bit sched(int tc);
    int f, h, v;
    f = tc / FR;
    h = tc % HT;
    v = (tc / HT) % VT;
    case (f)
      0:  return v == 5 && h == 3;
      2:  return v == VA && h == 0;
      3:  return (v == 3 || v == 8) && h == 10;
      4:  return v == VA + 1 && h == 5;
      6, 7, 8, 9: return $urandom_range(0, 299) == 0;
      10: return v == 6 && h == 20;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_reset_pins();
    check("rst_hs",   32'(s_hs), 32'd1);
    check("rst_vs",   32'(s_vs), 32'd1);
    check("rst_de",   32'(s_de), 32'd0);
    check("rst_rgb",  32'(s_rgb), 32'd0);
    check("rst_re",   32'(s_if.re), 32'd0);
    check("rst_addr", 32'(s_if.addr), 32'd0);
    check("rst_bank", 32'(s_bank), 32'd0);
    check("rst_vbl",  32'(s_vbl), 32'd0);
    check("rst_f_hs", 32'(f_hs), 32'd1);
    check("rst_f_de", 32'(f_de), 32'd0);
  endtask

  task automatic full_checks();
    if (t == 2)   check("f_de_pre",  32'(f_de), 32'd0);
    if (t == 3)   check("f_de_rise", 32'(f_de), 32'd1);
    if (t == 642) check("f_de_last", 32'(f_de), 32'd1);
    if (t == 643) check("f_de_fall", 32'(f_de), 32'd0);
    if (t == 658) check("f_hs_pre",  32'(f_hs), 32'd1);
    if (t == 659) check("f_hs_fall", 32'(f_hs), 32'd0);
    if (t == 754) check("f_hs_low",  32'(f_hs), 32'd0);
    if (t == 755) check("f_hs_rise", 32'(f_hs), 32'd1);
    if (t == 802) check("f_line_end", 32'(f_de), 32'd0);
    if (t == 803) check("f_line_per", 32'(f_de), 32'd1);
    if (t == 1601) check("f_brd_re",  32'(f_if.re), 32'd0);
    if (t == 1603) check("f_brd_rgb", 32'(f_rgb), 32'd0);
    if (t == 1603 + 576) check("f_brdr_rgb", 32'(f_rgb), 32'd0);
    if (t == 1603 + 639) check("f_brdr_de",  32'(f_de), 32'd1);
    if (t >= 1665 && t <= 1668) begin
      check("f_re", 32'(f_if.re), 32'd1);
      check("f_addr", 32'(f_if.addr),
            32'((1 << 8) | ((t - 1665) / 2)));
    end
    if (t >= 1667 && t <= 1670)
      check("f_rgb", 32'(f_rgb), 32'(PAL[(t - 1667) / 2]));
  endtask

  task automatic step();
    int h, v, y, x;
    bit act, img, rdy;
    ent_t e, e1, e3;
    h = t % HT;
    v = (t / HT) % VT;

    e3 = '{de: 0, hs: 1, vs: 1, re: 0, addr: '0, rgb: '0};
    e1 = e3;
    if (t >= 3) e3 = ring[(t - 3) % 4];
    if (t >= 1) e1 = ring[(t - 1) % 4];
    check("de",   32'(s_de),   32'(e3.de));
    check("hs",   32'(s_hs),   32'(e3.hs));
    check("vs",   32'(s_vs),   32'(e3.vs));
    check("rgb",  32'(s_rgb),  32'(e3.rgb));
    check("re",   32'(s_if.re),   32'(e1.re));
    check("addr", 32'(s_if.addr), 32'(e1.addr));
    check("bank", 32'(s_bank), 32'(mbank));
    check("vbl",  32'(s_vbl),  32'(mvbl));
    if (full_on) full_checks();

    rdy = sched_on ? sched(t) : 1'b0;
    frame_rdy = rdy;

    act = h < HA && v < VA;
    img = act && h >= XO && h < XO + 512;
    y = v / 2;
    x = (h - XO) / 2;
    e.de   = act;
    e.hs   = !(h >= HA + HFP && h < HA + HFP + HSY);
    e.vs   = !(v >= VA + VFP && v < VA + VFP + VSY);
    e.re   = img;
    e.addr = img ? 17'((int'(mbank) << 16) | (y << 8) | x) : '0;
    e.rgb  = img ? PAL[mem[e.addr] % 64] : 12'h000;
    ring[t % 4] = e;

    if (h == 0 && v == VA) begin
      mvbl = 1'b1;
      if (mpend || rdy) begin
        mbank = !mbank;
        mpend = 1'b0;
      end
    end else begin
      mpend = mpend | rdy;
      if (h == 0 && v == 0) mvbl = 1'b0;
    end

    @(negedge clk);
    t++;
  endtask

  task automatic restart();
    t = 0;
    mbank = 1'b0;
    mpend = 1'b0;
    mvbl  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    frame_rdy = 1'b0;
    t = 0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check_reset_pins();
    rstn = 1'b1;
    restart();
    sched_on = 1'b1;
    full_on  = 1'b1;
    while (t < 10 * FR + 12 * HT + 40) step();

    check("pend_pre_rst", 32'(mpend), 32'd1);
    frame_rdy = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_pins();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    restart();
    sched_on = 1'b0;
    full_on  = 1'b0;
    while (t < 2 * FR + 10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
